// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer with optional timed auto-scan.
// Optional feature macro: MUX_N_SCAN_SCAN_EN (divider counter and auto-scan mode).
module mux_n_scan #(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 3,
  parameter  int SCAN_DIV = 4,
  localparam int SELW     = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      sel_we,
  input  logic                      mode,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           chan,
  output logic [CHANNELS-1:0]       chan_onehot,
  output logic                      sel_err,
  output logic                      chg
);

  logic [SELW-1:0]     cur_sel;
  logic                sel_ok;
  logic [WIDTH-1:0]    dsel;
  logic [CHANNELS-1:0] oh;

  assign sel_ok = (32'(sel) < 32'(CHANNELS));

  // Explicit compare per channel keeps out-of-range codes from reaching the slice.
  always_comb begin
    dsel = '0;
    oh   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cur_sel == SELW'(k)) begin
        dsel  = din[k*WIDTH +: WIDTH];
        oh[k] = 1'b1;
      end
    end
  end

`ifdef MUX_N_SCAN_SCAN_EN
  localparam int DIVW = $clog2(SCAN_DIV);

  logic [DIVW-1:0] div;
  logic            mode_q;

  // Valid select wins over everything; a mode change clears the divider even on a rejected select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sel <= '0;
      div     <= '0;
      mode_q  <= 1'b0;
    end else begin
      mode_q <= mode;
      if (sel_we && sel_ok) begin
        cur_sel <= sel;
        div     <= '0;
      end else if (mode != mode_q) begin
        div <= '0;
      end else if (mode && !sel_we) begin
        if (div == DIVW'(SCAN_DIV - 1)) begin
          div     <= '0;
          cur_sel <= (cur_sel == SELW'(CHANNELS - 1)) ? '0 : cur_sel + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end
`else
  localparam int unused_scan_div = SCAN_DIV;
  logic unused_mode;
  assign unused_mode = mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sel <= '0;
    end else if (sel_we && sel_ok) begin
      cur_sel <= sel;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      chan        <= '0;
      chan_onehot <= '0;
      sel_err     <= 1'b0;
      chg         <= 1'b0;
    end else begin
      dout        <= dsel;
      chan        <= cur_sel;
      chan_onehot <= oh;
      sel_err     <= sel_we && !sel_ok;
      chg         <= (cur_sel != chan);
    end
  end

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed self-checking bench for mux_n_scan (WIDTH=5, CHANNELS=3, SCAN_DIV=4).
// Scan sequence is checked when MUX_N_SCAN_SCAN_EN is defined, manual-only behaviour otherwise.
module tb_mux_n_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] din;
  logic [1:0]  sel;
  logic        sel_we;
  logic        mode;
  logic [4:0]  dout;
  logic [1:0]  chan;
  logic [2:0]  chan_onehot;
  logic        sel_err;
  logic        chg;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  localparam logic [14:0] D1 = {5'd3, 5'd2, 5'd1};
  localparam logic [14:0] D2 = {5'd7, 5'd6, 5'd5};

  always #5 clk = ~clk;

  mux_n_scan #(.WIDTH(5), .CHANNELS(3), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .sel_we(sel_we), .mode(mode),
    .dout(dout), .chan(chan), .chan_onehot(chan_onehot), .sel_err(sel_err), .chg(chg)
  );

  typedef struct {
    logic [14:0] din;
    logic [1:0]  sel;
    logic        we;
    logic [4:0]  dout;
    logic [1:0]  chan;
    logic [2:0]  oh;
    logic        err;
    logic        chg;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_chan;
    logic       exp_chg;

    tbl[0]  = '{D1, 2'd2, 1'b1, 5'd1, 2'd0, 3'b001, 1'b0, 1'b0};
    tbl[1]  = '{D1, 2'd2, 1'b0, 5'd3, 2'd2, 3'b100, 1'b0, 1'b1};
    tbl[2]  = '{D1, 2'd2, 1'b0, 5'd3, 2'd2, 3'b100, 1'b0, 1'b0};
    tbl[3]  = '{D1, 2'd3, 1'b1, 5'd3, 2'd2, 3'b100, 1'b1, 1'b0};
    tbl[4]  = '{D1, 2'd3, 1'b0, 5'd3, 2'd2, 3'b100, 1'b0, 1'b0};
    tbl[5]  = '{D2, 2'd0, 1'b0, 5'd7, 2'd2, 3'b100, 1'b0, 1'b0};
    tbl[6]  = '{D2, 2'd1, 1'b1, 5'd7, 2'd2, 3'b100, 1'b0, 1'b0};
    tbl[7]  = '{D2, 2'd1, 1'b0, 5'd6, 2'd1, 3'b010, 1'b0, 1'b1};
    tbl[8]  = '{D2, 2'd0, 1'b1, 5'd6, 2'd1, 3'b010, 1'b0, 1'b0};
    tbl[9]  = '{D2, 2'd0, 1'b0, 5'd5, 2'd0, 3'b001, 1'b0, 1'b1};
    tbl[10] = '{D1, 2'd0, 1'b0, 5'd1, 2'd0, 3'b001, 1'b0, 1'b0};
    tbl[11] = '{D1, 2'd2, 1'b0, 5'd1, 2'd0, 3'b001, 1'b0, 1'b0};

    rst = 1'b1; din = D1; sel = '0; sel_we = 1'b0; mode = 1'b0;

    // Reset state, then first edge after release.
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_onehot", 32'(chan_onehot), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_dout", 32'(dout), 32'd1);
    chk("rel_chan", 32'(chan), 32'd0);
    chk("rel_onehot", 32'(chan_onehot), 32'b001);
    chk("rel_chg", 32'(chg), 32'd0);
    chk("rel_err", 32'(sel_err), 32'd0);

    // Manual-mode vectors: inputs before an edge, outputs checked after it.
    for (int i = 0; i < 12; i++) begin
      din = tbl[i].din; sel = tbl[i].sel; sel_we = tbl[i].we;
      @(negedge clk);
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
      chk($sformatf("v%0d_chan", i), 32'(chan), 32'(tbl[i].chan));
      chk($sformatf("v%0d_onehot", i), 32'(chan_onehot), 32'(tbl[i].oh));
      chk($sformatf("v%0d_err", i), 32'(sel_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_chg", i), 32'(chg), 32'(tbl[i].chg));
    end
    sel_we = 1'b0; din = D1;

    // Asynchronous reset mid-cycle with a select pending.
    sel = 2'd2; sel_we = 1'b1;
    @(negedge clk);
    sel_we = 1'b0;
    @(negedge clk);
    chk("pre_rst_chan", 32'(chan), 32'd2);
    sel = 2'd1; sel_we = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_chan", 32'(chan), 32'd0);
    chk("arst_onehot", 32'(chan_onehot), 32'd0);
    chk("arst_err", 32'(sel_err), 32'd0);
    chk("arst_chg", 32'(chg), 32'd0);
    @(negedge clk);
    chk("arst_hold_dout", 32'(dout), 32'd0);
    rst = 1'b0; sel_we = 1'b0;
    @(negedge clk);
    chk("arel_dout", 32'(dout), 32'd1);
    chk("arel_chan", 32'(chan), 32'd0);
    chk("arel_onehot", 32'(chan_onehot), 32'b001);
    chk("arel_chg", 32'(chg), 32'd0);

`ifdef MUX_N_SCAN_SCAN_EN
    // Scan from channel 0: mode-change edge clears div, advances every 4 edges;
    // a valid select on the div==3 cycle (before edge 21) overrides the advance.
    for (int i = 1; i <= 26; i++) begin
      mode = 1'b1; sel = 2'd1; sel_we = (i == 21);
      @(negedge clk);
      if (i <= 5)       exp_chan = 2'd0;
      else if (i <= 9)  exp_chan = 2'd1;
      else if (i <= 13) exp_chan = 2'd2;
      else if (i <= 17) exp_chan = 2'd0;
      else if (i <= 25) exp_chan = 2'd1;
      else              exp_chan = 2'd2;
      exp_chg = (i == 6) || (i == 10) || (i == 14) || (i == 18) || (i == 26);
      chk($sformatf("scan%0d_chan", i), 32'(chan), 32'(exp_chan));
      chk($sformatf("scan%0d_chg", i), 32'(chg), 32'(exp_chg));
    end
    sel_we = 1'b0;
    chk("scan_end_dout", 32'(dout), 32'd3);
`else
    for (int i = 1; i <= 20; i++) begin
      mode = 1'b1;
      @(negedge clk);
      chk($sformatf("noscan%0d_chan", i), 32'(chan), 32'd0);
      chk($sformatf("noscan%0d_chg", i), 32'(chg), 32'd0);
    end
    chk("noscan_dout", 32'(dout), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
